// File: rtl/scan_req_arbiter.sv
// scan_req_arbiter
//   Shares one register/memory access port between NUM_CH scan-chain request
//   channels. Each channel requests by toggling req_tgl (asynchronous scan
//   domain). Toggles are synchronised, edge-detected and latched as pending.
//   Pending channels are served one at a time, round-robin, over a req/ack
//   port. Completion is returned to the channel as a toggle on ack_tgl.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_tgl      per-channel request toggle (async)
//   ch_addr      per-channel address, packed NUM_CH x ADDR_W
//   ch_wdata     per-channel write data, packed NUM_CH x DATA_W
//   ch_wr        per-channel 1=write, 0=read
//   ack_tgl      per-channel completion toggle
//   ch_rdata     per-channel read data, valid when ack_tgl toggles
//   ch_err       per-channel timeout flag of the last completed request
//   ch_ovf       sticky per-channel overrun flag
//   reg_req      shared-port request, held until reg_ack or timeout
//   reg_wr       shared-port write enable
//   reg_addr     shared-port address
//   reg_wdata    shared-port write data
//   reg_ack      shared-port acknowledge (1-cycle pulse)
//   reg_rdata    shared-port read data, valid with reg_ack
//   busy         FSM not idle
module scan_req_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_tgl,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_wr,
    output logic [NUM_CH-1:0]        ack_tgl,
    output logic [NUM_CH*DATA_W-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [NUM_CH-1:0]        ch_ovf,
    output logic                     reg_req,
    output logic                     reg_wr,
    output logic [ADDR_W-1:0]        reg_addr,
    output logic [DATA_W-1:0]        reg_wdata,
    input  logic                     reg_ack,
    input  logic [DATA_W-1:0]        reg_rdata,
    output logic                     busy
);

    localparam int unsigned CW = $clog2(NUM_CH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0]        s1_q, s2_q, hold_q, pend_q, ovf_q;
    logic [CW-1:0]            ptr_q, gnt_q;
    logic [TW-1:0]            tcnt_q;
    logic                     req_q, wr_q, err_q, rupd_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q, rbuf_q;
    logic [NUM_CH-1:0]        ack_q, cherr_q;
    logic [NUM_CH*DATA_W-1:0] rdata_q;

    logic [NUM_CH-1:0]        det, in_svc, pend_set, pend_clr;
    logic                     found, grant_go, ack_hit, to_hit;
    logic [CW-1:0]            pick;

    // Round-robin search: first pending channel at or after ptr_q.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!found && pend_q[CW'((32'(ptr_q) + k) % NUM_CH)]) begin
                found = 1'b1;
                pick  = CW'((32'(ptr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_go = 1'b0;
        ack_hit  = 1'b0;
        to_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = ISSUE;
                    grant_go = 1'b1;
                end
            end
            ISSUE: begin
                // Acknowledge wins over a timeout in the same cycle.
                if (reg_ack) begin
                    state_d = DONE;
                    ack_hit = 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    to_hit  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        det      = s2_q ^ hold_q;
        in_svc   = '0;
        pend_clr = '0;
        if (state_q != IDLE) begin
            in_svc[gnt_q] = 1'b1;
        end
        if (grant_go) begin
            pend_clr[pick] = 1'b1;
        end
        // A toggle on a channel already pending or in service is an overrun,
        // not a second request.
        pend_set = det & ~pend_q & ~in_svc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            hold_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            s1_q   <= req_tgl;
            s2_q   <= s1_q;
            // hold_q only differs from s2_q on a detect edge, so an
            // unconditional copy is the same as "hold <= s2 on detect".
            hold_q <= s2_q;
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            ovf_q  <= ovf_q | (det & (pend_q | in_svc));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            tcnt_q  <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rupd_q  <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= '0;
            cherr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_go) begin
                gnt_q   <= pick;
                req_q   <= 1'b1;
                wr_q    <= ch_wr[pick];
                addr_q  <= ch_addr[pick*ADDR_W +: ADDR_W];
                wdata_q <= ch_wdata[pick*DATA_W +: DATA_W];
            end
            if (state_q == ISSUE) begin
                tcnt_q <= tcnt_q + 1'b1;
                if (ack_hit) begin
                    req_q  <= 1'b0;
                    err_q  <= 1'b0;
                    rupd_q <= ~wr_q;
                    rbuf_q <= reg_rdata;
                end else if (to_hit) begin
                    req_q  <= 1'b0;
                    err_q  <= 1'b1;
                    rupd_q <= 1'b0;
                end
            end
            if (state_q == DONE) begin
                if (rupd_q) begin
                    rdata_q[gnt_q*DATA_W +: DATA_W] <= rbuf_q;
                end
                cherr_q[gnt_q] <= err_q;
                ack_q[gnt_q]   <= ~ack_q[gnt_q];
                ptr_q          <= (gnt_q == CW'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
                tcnt_q         <= '0;
            end
        end
    end

    assign ack_tgl   = ack_q;
    assign ch_rdata  = rdata_q;
    assign ch_err    = cherr_q;
    assign ch_ovf    = ovf_q;
    assign reg_req   = req_q;
    assign reg_wr    = wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_scan_req_arbiter.sv
// tb_scan_req_arbiter
//   Directed scoreboard bench for scan_req_arbiter (TIMEOUT=8). Stimulus pushes
//   expected grants and completions into queues; a monitor pops and compares
//   on each reg_req rise and each ack_tgl change. A responder acks reg_req
//   immediately unless never_ack is set.
module tb_scan_req_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCH-1:0]      req_tgl = '0;
    logic [NCH*AW-1:0]   ch_addr = '0;
    logic [NCH*DW-1:0]   ch_wdata = '0;
    logic [NCH-1:0]      ch_wr = '0;
    logic [NCH-1:0]      ack_tgl;
    logic [NCH*DW-1:0]   ch_rdata;
    logic [NCH-1:0]      ch_err;
    logic [NCH-1:0]      ch_ovf;
    logic                reg_req;
    logic                reg_wr;
    logic [AW-1:0]       reg_addr;
    logic [DW-1:0]       reg_wdata;
    logic                reg_ack = 1'b0;
    logic [DW-1:0]       reg_rdata = '0;
    logic                busy;

    scan_req_arbiter #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_tgl  (req_tgl),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_wr    (ch_wr),
        .ack_tgl  (ack_tgl),
        .ch_rdata (ch_rdata),
        .ch_err   (ch_err),
        .ch_ovf   (ch_ovf),
        .reg_req  (reg_req),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_ack  (reg_ack),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        int unsigned   ch;
        logic [DW-1:0] rdata;
        logic          err;
    } cpl_t;

    gnt_t exp_gnt[$];
    cpl_t exp_cpl[$];
    int   n_vec = 0;
    int   n_fail = 0;
    logic never_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string msg);
        n_vec++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    task automatic set_ch(input int unsigned ch, input logic [AW-1:0] a,
                          input logic wr, input logic [DW-1:0] wd);
        ch_addr[ch*AW +: AW]  = a;
        ch_wr[ch]             = wr;
        ch_wdata[ch*DW +: DW] = wd;
    endtask

    task automatic expect_xact(input int unsigned ch, input logic [AW-1:0] a,
                               input logic wr, input logic [DW-1:0] wd,
                               input logic [DW-1:0] rd, input logic err);
        gnt_t g;
        cpl_t c;
        g.addr = a; g.wr = wr; g.wdata = wd;
        c.ch = ch; c.rdata = rd; c.err = err;
        exp_gnt.push_back(g);
        exp_cpl.push_back(c);
    endtask

    task automatic tog(input logic [NCH-1:0] m);
        req_tgl = req_tgl ^ m;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_gnt.size() != 0 || exp_cpl.size() != 0) && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (k >= 400) flag_fail("drain: expected transactions never completed");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int k = 0;
        @(posedge clk); #1;
        while (!reg_req && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!reg_req) flag_fail("wait_req: reg_req never rose");
    endtask

    task automatic wait_ack(input int unsigned i);
        logic old;
        int   k = 0;
        old = ack_tgl[i];
        @(posedge clk); #1;
        while (ack_tgl[i] == old && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (ack_tgl[i] == old) flag_fail("wait_ack: ack_tgl never toggled");
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n   = 1'b0;
        req_tgl = '0;
        exp_gnt.delete();
        exp_cpl.delete();
        #1;
        chk("reset reg_req", reg_req, 0);
        chk("reset busy", busy, 0);
        chk("reset ack_tgl", ack_tgl, 0);
        chk("reset ch_ovf", ch_ovf, 0);
        chk("reset ch_err", ch_err, 0);
        chk("reset ch_rdata", ch_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Responder: single-cycle ack as soon as reg_req is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && reg_req && !never_ack && !reg_ack) begin
                reg_ack   = 1'b1;
                reg_rdata = (reg_addr == 8'h12) ? 16'hBEEF : {8'hA5, reg_addr};
            end else begin
                reg_ack   = 1'b0;
                reg_rdata = 16'hDEAD;
            end
        end
    end

    // Monitor
    initial begin
        logic           prev_req;
        logic [NCH-1:0] prev_ack;
        gnt_t           g;
        cpl_t           c;
        prev_req = 1'b0;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                prev_ack = '0;
            end else begin
                if (reg_req && !prev_req) begin
                    if (exp_gnt.size() == 0) begin
                        flag_fail($sformatf("unexpected grant addr 0x%0h", reg_addr));
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("grant reg_addr", reg_addr, g.addr);
                        chk("grant reg_wr", reg_wr, g.wr);
                        if (g.wr) chk("grant reg_wdata", reg_wdata, g.wdata);
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    if (ack_tgl[i] != prev_ack[i]) begin
                        if (exp_cpl.size() == 0) begin
                            flag_fail($sformatf("unexpected ack_tgl change on ch%0d", i));
                        end else begin
                            c = exp_cpl.pop_front();
                            chk("ack channel", i, c.ch);
                            chk("ch_rdata", ch_rdata[i*DW +: DW], c.rdata);
                            chk("ch_err", ch_err[i], c.err);
                        end
                    end
                end
                prev_req = reg_req;
                prev_ack = ack_tgl;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int cnt;

        // Single read, latency check
        do_reset();
        set_ch(0, 8'h12, 1'b0, 16'h0000);
        expect_xact(0, 8'h12, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
        @(posedge clk); #1;
        tog(4'b0001);
        repeat (3) @(posedge clk);
        #1;
        chk("latency reg_req after 3 edges", reg_req, 0);
        @(posedge clk); #1;
        chk("latency reg_req after 4 edges", reg_req, 1);
        chk("busy in ISSUE", busy, 1);
        drain();
        chk("single read ack_tgl", ack_tgl, 4'b0001);

        // Simultaneous requests from pointer 0
        do_reset();
        for (int unsigned i = 0; i < NCH; i++) set_ch(i, 8'h20 + 8'(i), 1'b0, 16'h0000);
        expect_xact(0, 8'h20, 1'b0, 16'h0, 16'hA520, 1'b0);
        expect_xact(1, 8'h21, 1'b0, 16'h0, 16'hA521, 1'b0);
        expect_xact(2, 8'h22, 1'b0, 16'h0, 16'hA522, 1'b0);
        expect_xact(3, 8'h23, 1'b0, 16'h0, 16'hA523, 1'b0);
        @(posedge clk); #1;
        tog(4'b1111);
        drain();
        chk("all-channel ack_tgl", ack_tgl, 4'b1111);
        set_ch(0, 8'h24, 1'b0, 16'h0000);
        set_ch(3, 8'h27, 1'b0, 16'h0000);
        expect_xact(0, 8'h24, 1'b0, 16'h0, 16'hA524, 1'b0);
        expect_xact(3, 8'h27, 1'b0, 16'h0, 16'hA527, 1'b0);
        tog(4'b1001);
        drain();
        chk("pair ack_tgl", ack_tgl, 4'b0110);

        // Fairness: ch1 read re-requests after each ack, ch2 write keeps
        // re-requesting; writes must not disturb ch_rdata[2].
        set_ch(1, 8'h31, 1'b0, 16'h0000);
        set_ch(2, 8'h42, 1'b1, 16'h1234);
        for (int r = 0; r < 4; r++) begin
            expect_xact(1, 8'h31, 1'b0, 16'h0000, 16'hA531, 1'b0);
            expect_xact(2, 8'h42, 1'b1, 16'h1234, 16'hA522, 1'b0);
        end
        tog(4'b0110);
        for (int r = 0; r < 3; r++) begin
            wait_ack(1);
            tog(4'b0010);
            wait_ack(2);
            tog(4'b0100);
        end
        drain();

        // Timeout on ch3, then a normal read clears the error
        never_ack = 1'b1;
        set_ch(3, 8'h77, 1'b0, 16'h0000);
        expect_xact(3, 8'h77, 1'b0, 16'h0, 16'hA527, 1'b1);
        tog(4'b1000);
        wait_req();
        cnt = 0;
        while (reg_req && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("timeout reg_req high cycles", cnt, 8);
        never_ack = 1'b0;
        drain();
        set_ch(3, 8'h78, 1'b0, 16'h0000);
        expect_xact(3, 8'h78, 1'b0, 16'h0, 16'hA578, 1'b0);
        tog(4'b1000);
        drain();

        // Overrun on ch2
        chk("ch_ovf clear before overrun", ch_ovf, 0);
        set_ch(2, 8'h60, 1'b0, 16'h0000);
        expect_xact(2, 8'h60, 1'b0, 16'h0, 16'hA560, 1'b0);
        tog(4'b0100);
        repeat (2) @(posedge clk);
        #1;
        tog(4'b0100);
        drain();
        repeat (10) @(posedge clk);
        #1;
        chk("ch_ovf after double toggle", ch_ovf, 4'b0100);
        set_ch(2, 8'h61, 1'b0, 16'h0000);
        expect_xact(2, 8'h61, 1'b0, 16'h0, 16'hA561, 1'b0);
        tog(4'b0100);
        drain();
        chk("ch_ovf sticky", ch_ovf, 4'b0100);

        // Reset while in ISSUE
        never_ack = 1'b1;
        set_ch(0, 8'h55, 1'b0, 16'h0000);
        expect_xact(0, 8'h55, 1'b0, 16'h0, 16'h0000, 1'b0);
        tog(4'b0001);
        wait_req();
        chk("reg_req high before reset", reg_req, 1);
        do_reset();
        never_ack = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post-reset reg_req idle", reg_req, 0);
        chk("post-reset busy", busy, 0);
        chk("post-reset ack_tgl", ack_tgl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
